template_fifo: RTL and testbench



---
 rtl/template_fifo.sv | 77 +++++++
 tb/tb_template_fifo.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/template_fifo.sv
// template_fifo: parametrised single-clock FIFO with valid/ready handshakes, occupancy count,
// almost-full flag, synchronous flush and sticky overflow flag.
module template_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 2**ADDR_WIDTH - 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  overflow_err
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT   = (ADDR_WIDTH+1)'(AFULL_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  push, pop;

    assign in_ready     = (count_q != FULL_CNT);
    assign out_valid    = (count_q != '0);
    assign out_data     = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count        = count_q;
    assign almost_full  = (count_q >= AF_CNT);
    assign overflow_err = ovf_q;
    assign push         = in_valid & in_ready;
    assign pop          = out_valid & out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            wr_ptr_d = push ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
            rd_ptr_d = pop ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
            count_d  = (push && !pop) ? count_q + (ADDR_WIDTH+1)'(1) :
                       (pop && !push) ? count_q - (ADDR_WIDTH+1)'(1) : count_q;
            ovf_d    = ovf_q | (in_valid & ~in_ready);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is deliberately not reset; out_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[wr_ptr_q] <= in_data;
    end
endmodule

// File: tb/tb_template_fifo.sv
// tb_template_fifo: directed stimulus with a queue scoreboard checked by an independent monitor.
module tb_template_fifo;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [4:0] count;
    logic       almost_full;
    logic       overflow_err;

    int passed = 0;
    int total  = 0;
    logic [7:0] exp_q [$];

    template_fifo dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .almost_full(almost_full), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    endtask

    // Monitor: a pop is committed at the next posedge when out_valid & out_ready hold now.
    initial forever begin
        @(negedge clk);
        #1;
        if (!reset && !clear && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_pop", {24'h0, out_data}, 32'hFFFF_FFFF);
            else chk("pop_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_almost_full", almost_full, 0);
        chk("rst_overflow", overflow_err, 0);
        @(negedge clk);
        reset = 1'b0;

        // Fill to full with out_ready low.
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i > 1) chk("fill_almost_full", almost_full, (i - 1) >= 14);
            in_valid = 1'b1;
            in_data  = 8'(i);
            exp_q.push_back(8'(i));
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("full_count", count, 16);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_data", out_data, 8'h01);
        chk("full_almost_full", almost_full, 1);

        // Push at full while popping: push dropped, overflow flagged.
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ovf_count", count, 15);
        chk("ovf_flag", overflow_err, 1);
        repeat (15) @(negedge clk);
        chk("drain_count", count, 0);
        chk("drain_out_valid", out_valid, 0);
        chk("drain_out_data", out_data, 0);
        chk("drain_ovf_sticky", overflow_err, 1);
        out_ready = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_ovf", overflow_err, 0);

        // Streaming with pointer wrap.
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) chk("stream_first_empty", out_valid, 0);
            else begin
                chk("stream_count", count, 1);
                chk("stream_out_valid", out_valid, 1);
            end
            in_valid = 1'b1;
            in_data  = 8'(i);
            exp_q.push_back(8'(i));
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        chk("stream_end_count", count, 0);

        // Clear with simultaneous push and pop.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'(8'h30 + i);
        end
        @(negedge clk);
        chk("pre_clear_count", count, 5);
        clear     = 1'b1;
        in_data   = 8'h77;
        out_ready = 1'b1;
        @(negedge clk);
        clear     = 1'b0;
        in_valid  = 1'b0;
        chk("post_clear_count", count, 0);
        chk("post_clear_out_valid", out_valid, 0);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        exp_q.push_back(8'h5A);
        @(negedge clk);
        in_valid = 1'b0;
        chk("after_clear_head", out_data, 8'h5A);
        @(negedge clk);
        out_ready = 1'b0;

        // Asynchronous reset mid-cycle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'(8'hC0 + i);
            exp_q.push_back(8'(8'hC0 + i));
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_reset_count", count, 3);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_out_valid", out_valid, 0);
        chk("post_reset_out_data", out_data, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
